// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the 1101 sequence detectors: WIDTH-bit words in
// over valid/ready, one registered bit per clock out, with a holding register for gap-free streaming.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_hr;
  logic             r_hrFull;
  logic [CW-1:0]    r_cnt;
  logic             r_x;
  logic             r_xValid;
  logic             r_wordDone;

  logic             w_accept;
  logic             w_lastBit;
  logic [CW-1:0]    w_cntNext;
  logic [WIDTH-1:0] w_loadWord;
  logic             w_loadFirst;
  logic [WIDTH-1:0] w_loadRest;
  logic             w_shiftBit;
  logic [WIDTH-1:0] w_shiftRest;

  assign din_ready = ~r_hrFull & ~RESET;
  assign w_accept  = din_valid & din_ready;
  assign w_lastBit = (r_state == S_SHIFT) && (r_cnt == LAST);
  assign w_cntNext = r_cnt + 1'b1;

  // On the last bit a pending HR word takes precedence over the bypass path from din.
  assign w_loadWord = (w_lastBit && r_hrFull) ? r_hr : din;

  // SR holds only the bits not yet on x, so the next bit always sits at the outgoing end.
  assign w_loadFirst = MSB_FIRST ? w_loadWord[WIDTH-1] : w_loadWord[0];
  assign w_loadRest  = MSB_FIRST ? {w_loadWord[WIDTH-2:0], 1'b0}
                                 : {1'b0, w_loadWord[WIDTH-1:1]};
  assign w_shiftBit  = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
  assign w_shiftRest = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_sr[WIDTH-1:1]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_hr       <= '0;
      r_hrFull   <= 1'b0;
      r_cnt      <= '0;
      r_x        <= IDLE_BIT;
      r_xValid   <= 1'b0;
      r_wordDone <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x        <= w_loadFirst;
            r_sr       <= w_loadRest;
            r_cnt      <= '0;
            r_xValid   <= 1'b1;
            r_wordDone <= 1'b0;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!w_lastBit) begin
            r_x        <= w_shiftBit;
            r_sr       <= w_shiftRest;
            r_cnt      <= w_cntNext;
            r_wordDone <= (w_cntNext == LAST);
            if (w_accept) begin
              r_hr     <= din;
              r_hrFull <= 1'b1;
            end
          end else if (r_hrFull || w_accept) begin
            r_x        <= w_loadFirst;
            r_sr       <= w_loadRest;
            r_cnt      <= '0;
            r_xValid   <= 1'b1;
            r_wordDone <= 1'b0;
            r_hrFull   <= 1'b0;
          end else begin
            r_x        <= IDLE_BIT;
            r_xValid   <= 1'b0;
            r_wordDone <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign x         = r_x;
  assign x_valid   = r_xValid;
  assign word_done = r_wordDone;
  assign busy      = r_xValid | r_hrFull;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: a cycle table for the MSB-first/idle-0 instance,
// plus a hand-written sequence for the LSB-first/idle-1 instance.
module tb_seq_serializer;

  typedef struct {
    logic       rst;
    logic       v;
    logic [3:0] din;
    logic       expReady;
    logic       expX;
    logic       expXv;
    logic       expWd;
    logic       expBusy;
  } vec_t;

  logic       CLK;
  logic       rstA, vA;
  logic [3:0] dinA;
  logic       readyA, xA, xvA, wdA, busyA;
  logic       rstB, vB;
  logic [3:0] dinB;
  logic       readyB, xB, xvB, wdB, busyB;

  int checks;
  int failures;
  vec_t vecs[$];

  seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutA (
    .CLK(CLK), .RESET(rstA), .din(dinA), .din_valid(vA), .din_ready(readyA),
    .x(xA), .x_valid(xvA), .word_done(wdA), .busy(busyA)
  );

  seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dutB (
    .CLK(CLK), .RESET(rstB), .din(dinB), .din_valid(vB), .din_ready(readyB),
    .x(xB), .x_valid(xvB), .word_done(wdB), .busy(busyB)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic vec_t mk(logic rst, logic v, logic [3:0] din, logic rdy,
                              logic ex, logic exv, logic ewd, logic eb);
    vec_t t;
    t.rst = rst; t.v = v; t.din = din; t.expReady = rdy;
    t.expX = ex; t.expXv = exv; t.expWd = ewd; t.expBusy = eb;
    return t;
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s step=%0d got=%b want=%b", name, idx, act, exp);
    end
  endtask

  // Drive one table row: din_ready is checked before the edge, registered outputs after it.
  task automatic applyStimulus(input vec_t t, input int idx);
    rstA = t.rst; vA = t.v; dinA = t.din;
    #1;
    checkOutput("A_din_ready", idx, readyA, t.expReady);
    @(posedge CLK); #1;
    checkOutput("A_x", idx, xA, t.expX);
    checkOutput("A_x_valid", idx, xvA, t.expXv);
    checkOutput("A_word_done", idx, wdA, t.expWd);
    checkOutput("A_busy", idx, busyA, t.expBusy);
    checkOutput("B_x_in_reset", idx, xB, 1'b1);
  endtask

  task automatic stepB(input logic v, input logic [3:0] din, input logic expReady,
                       input logic ex, input logic exv, input logic ewd, input int idx);
    vB = v; dinB = din;
    #1;
    checkOutput("B_din_ready", idx, readyB, expReady);
    @(posedge CLK); #1;
    checkOutput("B_x", idx, xB, ex);
    checkOutput("B_x_valid", idx, xvB, exv);
    checkOutput("B_word_done", idx, wdB, ewd);
  endtask

  initial begin
    checks = 0; failures = 0;
    rstA = 1'b1; vA = 1'b0; dinA = '0;
    rstB = 1'b1; vB = 1'b0; dinB = '0;

    //                rst  v   din      rdy  x  xv wd busy
    // reset with valid offered
    vecs.push_back(mk(1'b1,1'b1,4'b1111, 1'b0,1'b0,1'b0,1'b0,1'b0));
    // single word 1101
    vecs.push_back(mk(1'b0,1'b1,4'b1101, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b0,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b1,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b0,1'b0,1'b0,1'b0));
    // back-to-back 1101, 1011, 0110; 1111 offered while HR full must be ignored
    vecs.push_back(mk(1'b0,1'b1,4'b1101, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b1,4'b1011, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b1,4'b0110, 1'b0,1'b0,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b1,4'b0110, 1'b0,1'b1,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b1,4'b0110, 1'b0,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b1,4'b0110, 1'b1,1'b0,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b1,4'b1111, 1'b0,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b1,4'b1111, 1'b0,1'b1,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b1,4'b1111, 1'b0,1'b0,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b1111, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b0,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b0,1'b0,1'b0,1'b0));
    // bypass: next word offered exactly in the last-bit cycle, din wiggles while not valid
    vecs.push_back(mk(1'b0,1'b1,4'b1101, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b1111, 1'b1,1'b0,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b1,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b1,4'b0110, 1'b1,1'b0,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b1001, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b1001, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b1001, 1'b1,1'b0,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b0,1'b0,1'b0,1'b0));
    // reset after two bits of 1101 with 1111 held in HR, then a clean 0011
    vecs.push_back(mk(1'b0,1'b1,4'b1101, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b1,4'b1111, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b1,1'b1,4'b1010, 1'b0,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b1,4'b0011, 1'b1,1'b0,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b0,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b1,1'b1,1'b0,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b1,1'b1,1'b1,1'b1));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b0,1'b0,1'b0,1'b0));
    vecs.push_back(mk(1'b0,1'b0,4'b0000, 1'b1,1'b0,1'b0,1'b0,1'b0));

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // LSB-first, idle-high instance: 1101 goes out as 1,0,1,1 then rests at 1
    rstB = 1'b0;
    stepB(1'b1, 4'b1101, 1'b1, 1'b1, 1'b1, 1'b0, 100);
    stepB(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 101);
    stepB(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 102);
    stepB(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 103);
    stepB(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 104);
    stepB(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 105);

    // reset B mid-word: x must go straight to the idle-high level
    stepB(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 106);
    stepB(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 107);
    rstB = 1'b1;
    stepB(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 108);
    stepB(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 109);
    checkOutput("B_busy_reset", 109, busyB, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
